// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU internal-operation sequencer.
//
// Contents:
//   OP_NONE/OP_MOV/OP_INC/OP_DEC : request operation encoding.
//   seq_state_t                   : IDLE / SETUP / EXEC / DONE.
//   LINE_ASSERT / LINE_IDLE       : levels of the active-low decoder override lines.
//   ctrl_lines_t, encode_lines()  : mapping from an operation to the four lines.
package alu_seq_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic LINE_ASSERT = 1'b0;
    localparam logic LINE_IDLE   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic mov;
        logic addr;
        logic inc_dec;
        logic dec;
    } ctrl_lines_t;

    localparam ctrl_lines_t LINES_RELEASED = '{LINE_IDLE, LINE_IDLE, LINE_IDLE, LINE_IDLE};

    // Every real operation overrides the MOV line; INC and DEC additionally pull
    // INC_DEC, and only DEC pulls DEC. OP_NONE never drives anything.
    function automatic ctrl_lines_t encode_lines(input logic [1:0] op, input logic addr_mode);
        ctrl_lines_t l;
        l = LINES_RELEASED;
        if (op != OP_NONE) begin
            l.mov     = LINE_ASSERT;
            l.addr    = addr_mode ? LINE_ASSERT : LINE_IDLE;
            l.inc_dec = (op == OP_MOV) ? LINE_IDLE : LINE_ASSERT;
            l.dec     = (op == OP_DEC) ? LINE_ASSERT : LINE_IDLE;
        end
        return l;
    endfunction

endpackage

// File: rtl/alu_internal_seq_if.sv
// Request / control-line bundle between the instruction control unit (master)
// and the internal-operation sequencer (slave).
//
// Master drives : req, op, addr_mode, count, flush.
// Slave drives  : ack, busy, done, reg_we, step_idx and the four active-low
//                 decoder override lines.
interface alu_internal_seq_if #(parameter int CNT_W = 4);
    logic             req;
    logic [1:0]       op;
    logic             addr_mode;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             ack;
    logic             busy;
    logic             done;
    logic             reg_we;
    logic [CNT_W-1:0] step_idx;
    logic             INTERNAL_MOV;
    logic             ADDRESS_MODE;
    logic             INTERNAL_INC_DEC;
    logic             INTERNAL_DEC;

    modport master (
        output req, op, addr_mode, count, flush,
        input  ack, busy, done, reg_we, step_idx,
               INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC
    );

    modport slave (
        input  req, op, addr_mode, count, flush,
        output ack, busy, done, reg_we, step_idx,
               INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC
    );
endinterface

// File: rtl/alu_step_counter.sv
// Small up-counter with terminal-count flag, used both for the setup delay and
// for the per-step index of the sequencer.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   load       : return the count to zero (has priority over enable).
//   enable     : advance by one.
//   last       : terminal value; tc is high while value == last.
//   value      : current count.
//   tc         : terminal-count flag.
module alu_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] value,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= '0;
        end else if (enable) begin
            value <= value + CNT_W'(1);
        end
    end

    assign tc = (value == last);

endmodule

// File: rtl/alu_internal_seq.sv
// Sequencer that drives the active-low internal-operation override lines of the
// ALU decoder bank. A request is latched, the lines are held through a setup
// delay and count+1 write steps, then a single DONE cycle releases them.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : slave side of alu_internal_seq_if (request, handshake, write
//                strobe, step index and the four override lines).
//
// Every output is a flop loaded from the next-state decode, so nothing combines
// the request inputs straight through to the decoder lines.
module alu_internal_seq
    import alu_seq_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int SETUP_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_internal_seq_if.slave   bus
);

    seq_state_t       state, state_next;
    logic [1:0]       op_q;
    logic             addr_q;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic             ack_next, done_next;
    ctrl_lines_t      lines_q, lines_next;
    logic             ack_q, busy_q, done_q, we_q;

    logic             setup_load, step_load;
    logic             setup_tc, step_tc;
    logic [CNT_W-1:0] setup_val, step_val;

    // Both counters sit at zero except while their own state persists, so each
    // phase starts counting from zero and step_idx is zero outside EXEC.
    assign setup_load = !(state == SETUP && state_next == SETUP);
    assign step_load  = !(state == EXEC  && state_next == EXEC);

    alu_step_counter #(.CNT_W(CNT_W)) u_setup_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (setup_load),
        .enable (!setup_load),
        .last   (CNT_W'(SETUP_CYC - 1)),
        .value  (setup_val),
        .tc     (setup_tc)
    );

    alu_step_counter #(.CNT_W(CNT_W)) u_step_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (step_load),
        .enable (!step_load),
        .last   (count_q),
        .value  (step_val),
        .tc     (step_tc)
    );

    // DONE accepts a new request exactly like IDLE so back-to-back operations
    // are separated by a single released-lines cycle. Flush always wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_next   = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.req && !bus.flush) begin
                    accept   = 1'b1;
                    ack_next = 1'b1;
                    if (bus.op == OP_NONE) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (setup_tc) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (step_tc) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // On the accepting edge the request fields are not latched yet, so the line
    // encoding is taken from the bus in that one case.
    always_comb begin
        lines_next = LINES_RELEASED;
        if (state_next == SETUP || state_next == EXEC) begin
            lines_next = accept ? encode_lines(bus.op, bus.addr_mode)
                                : encode_lines(op_q, addr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_NONE;
            addr_q  <= 1'b0;
            count_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            lines_q <= LINES_RELEASED;
        end else begin
            state   <= state_next;
            if (accept) begin
                op_q    <= bus.op;
                addr_q  <= bus.addr_mode;
                count_q <= bus.count;
            end
            ack_q   <= ack_next;
            busy_q  <= (state_next != IDLE);
            done_q  <= done_next;
            we_q    <= (state_next == EXEC);
            lines_q <= lines_next;
        end
    end

    assign bus.ack              = ack_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.reg_we           = we_q;
    assign bus.step_idx         = step_val;
    assign bus.INTERNAL_MOV     = lines_q.mov;
    assign bus.ADDRESS_MODE     = lines_q.addr;
    assign bus.INTERNAL_INC_DEC = lines_q.inc_dec;
    assign bus.INTERNAL_DEC     = lines_q.dec;

endmodule

// File: tb/tb_alu_internal_seq.sv
// Self-checking bench for alu_internal_seq. The expected per-cycle output of an
// operation is derived from its timeline: ack in cycle 1, lines held until the
// done cycle at 1+SETUP+count+1, write strobes in the last count+1 held cycles.
module tb_alu_internal_seq;

    localparam int CNT_W = 4;
    localparam int SETUP = 1;
    // {ack, busy, done, reg_we, step_idx[3:0], MOV, ADDRESS_MODE, INC_DEC, DEC}
    localparam logic [11:0] IDLE_VEC = 12'h00F;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_internal_seq_if #(.CNT_W(CNT_W)) bus ();

    alu_internal_seq #(.CNT_W(CNT_W), .SETUP_CYC(SETUP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in cycle k after the request was first sampled (k=1 is
    // the first cycle after the accepting edge).
    function automatic logic [11:0] model(input logic [1:0] op, input logic am,
                                          input int cnt, input int k);
        logic       ack, busy, done, we;
        logic [3:0] idx;
        logic [3:0] lines;
        int         total;
        ack = 0; busy = 0; done = 0; we = 0; idx = 0; lines = 4'b1111;
        if (op == 2'b00) begin
            if (k == 1) begin
                ack = 1; busy = 1; done = 1;
            end
        end else begin
            total = 1 + SETUP + cnt + 1;
            if (k >= 1 && k < total) begin
                busy  = 1;
                ack   = (k == 1);
                lines = {1'b0, ~am, (op == 2'b01), (op != 2'b11)};
                if (k > SETUP) begin
                    we  = 1;
                    idx = 4'(k - SETUP - 1);
                end
            end else if (k == total) begin
                busy = 1; done = 1;
            end
        end
        return {ack, busy, done, we, idx, lines};
    endfunction

    function automatic logic [11:0] observed();
        return {bus.ack, bus.busy, bus.done, bus.reg_we, bus.step_idx,
                bus.INTERNAL_MOV, bus.ADDRESS_MODE, bus.INTERNAL_INC_DEC, bus.INTERNAL_DEC};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.op        = 2'($urandom);
        bus.addr_mode = 1'($urandom);
        bus.count     = 4'($urandom);
    endtask

    task automatic test_reset();
        logic [11:0] act;
        rst_n = 1'b0;
        bus.req = 0; bus.op = 0; bus.addr_mode = 0; bus.count = 0; bus.flush = 0;
        tick(); tick();
        act = observed();
        checks++;
        if (act !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected %b", act, IDLE_VEC);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            act = observed();
            checks++;
            if (act !== IDLE_VEC) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, act, IDLE_VEC);
            end
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        logic        ams [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          cnts[6] = '{0, 3, 0, 0, 15, 1};
        logic [11:0] act, exp_v;
        int          total;
        for (int t = 0; t < 6; t++) begin
            bus.req = 1; bus.op = ops[t]; bus.addr_mode = ams[t]; bus.count = 4'(cnts[t]);
            total = (ops[t] == 2'b00) ? 1 : SETUP + cnts[t] + 2;
            for (int k = 1; k <= total + 1; k++) begin
                tick();
                if (k == 1) begin
                    bus.req = 0;
                    scramble_inputs();
                end
                act   = observed();
                exp_v = model(ops[t], ams[t], cnts[t], k);
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL directed case %0d cycle %0d: got %b expected %b", t, k, act, exp_v);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic        am;
        int          cnt, total;
        logic [11:0] act, exp_v;
        for (int t = 0; t < 25; t++) begin
            op  = 2'($urandom);
            am  = 1'($urandom);
            cnt = int'($urandom_range(0, 15));
            bus.req = 1; bus.op = op; bus.addr_mode = am; bus.count = 4'(cnt);
            total = (op == 2'b00) ? 1 : SETUP + cnt + 2;
            for (int k = 1; k <= total + 1; k++) begin
                tick();
                if (k == 1) bus.req = 0;
                scramble_inputs();
                act   = observed();
                exp_v = model(op, am, cnt, k);
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL random op %0d cycle %0d: got %b expected %b", t, k, act, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] act, exp_v;
        // First: MOV count=0 (done in cycle 3); second: INC count=2 accepted
        // leaving DONE, so its cycle 1 is overall cycle 4.
        bus.req = 1; bus.op = 2'b01; bus.addr_mode = 0; bus.count = 4'd0;
        for (int k = 1; k <= 3 + SETUP + 2 + 2 + 1; k++) begin
            tick();
            if (k == 1) begin
                bus.op = 2'b10; bus.addr_mode = 1; bus.count = 4'd2;
            end
            if (k == 4) begin
                bus.req = 0;
                scramble_inputs();
            end
            exp_v = (k <= 3) ? model(2'b01, 1'b0, 0, k) : model(2'b10, 1'b1, 2, k - 3);
            act   = observed();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", k, act, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        logic [11:0] act, exp_v;
        // Abort a DEC count=5 during step 1.
        bus.req = 1; bus.op = 2'b11; bus.addr_mode = 0; bus.count = 4'd5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) bus.req = 0;
            act   = observed();
            exp_v = model(2'b11, 1'b0, 5, k);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("[TB] FAIL flush_pre cycle %0d: got %b expected %b", k, act, exp_v);
            end
        end
        bus.flush = 1;
        tick();
        bus.flush = 0;
        for (int i = 0; i < 3; i++) begin
            act = observed();
            checks++;
            if (act !== IDLE_VEC) begin
                errors++;
                $display("[TB] FAIL flush_exec cycle %0d: got %b expected %b", i, act, IDLE_VEC);
            end
            tick();
        end
        // flush together with req in IDLE: no ack, nothing starts.
        bus.req = 1; bus.flush = 1; bus.op = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            act = observed();
            checks++;
            if (act !== IDLE_VEC) begin
                errors++;
                $display("[TB] FAIL flush_idle cycle %0d: got %b expected %b", i, act, IDLE_VEC);
            end
        end
        bus.req = 0; bus.flush = 0;
        // flush arriving in the DONE cycle does not cancel done.
        bus.req = 1; bus.op = 2'b01; bus.addr_mode = 1; bus.count = 4'd0;
        for (int k = 1; k <= SETUP + 3; k++) begin
            tick();
            if (k == 1) bus.req = 0;
            if (k == SETUP + 2) bus.flush = 1;
            if (k == SETUP + 3) bus.flush = 0;
            act   = observed();
            exp_v = model(2'b01, 1'b1, 0, k);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("[TB] FAIL flush_done cycle %0d: got %b expected %b", k, act, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] act, exp_v;
        bus.req = 1; bus.op = 2'b10; bus.addr_mode = 1; bus.count = 4'd5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) bus.req = 0;
            act   = observed();
            exp_v = model(2'b10, 1'b1, 5, k);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %b expected %b", k, act, exp_v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        act = observed();
        checks++;
        if (act !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: got %b expected %b", act, IDLE_VEC);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            act = observed();
            checks++;
            if (act !== IDLE_VEC) begin
                errors++;
                $display("[TB] FAIL reset_mid_after cycle %0d: got %b expected %b", i, act, IDLE_VEC);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
